// File: rtl/sap_clock_ctrl_if.sv
// Button-event and clock-enable bundle between the debouncers/CPU side and sap_clock_ctrl.
// master drives the button pulses and hlt; slave (the controller) drives the enable and status.
interface sap_clock_ctrl_if #(
  parameter int WIDTH = 24
);
  localparam int RW = $clog2(WIDTH);

  logic          step_pb;
  logic          mode_pb;
  logic          faster_pb;
  logic          slower_pb;
  logic          hlt;
  logic          cpu_ce;
  logic          auto_mode;
  logic          halted;
  logic [RW-1:0] rate;

  modport master (
    output step_pb, mode_pb, faster_pb, slower_pb, hlt,
    input  cpu_ce, auto_mode, halted, rate
  );

  modport slave (
    input  step_pb, mode_pb, faster_pb, slower_pb, hlt,
    output cpu_ce, auto_mode, halted, rate
  );
endinterface

// File: rtl/sap_clock_ctrl.sv
// SAP-1 clock-enable controller: manual single-step or auto free-run at 2^rate cycles,
// with a sticky halt that only clr releases.
module sap_clock_ctrl #(
  parameter int WIDTH     = 24,
  parameter int RATE_INIT = 10
) (
  input  logic               clk,
  input  logic               clr,
  sap_clock_ctrl_if.slave    bus
);
  localparam int RW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    MANUAL      = 2'b00,
    AUTO        = 2'b01,
    HALT_MANUAL = 2'b10,
    HALT_AUTO   = 2'b11
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] period_max_s;
  logic [RW-1:0]    rate_r, rate_s;
  logic             cpu_ce_r, cpu_ce_s;
  logic             auto_mode_r, halted_r;
  logic             auto_cur_s, auto_nxt_s;
  logic             halt_cur_s, halt_nxt_s;
  logic             rate_chg_s, wrap_s;

  // State, counter, rate and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r     <= MANUAL;
      cnt_r       <= '0;
      rate_r      <= RW'(RATE_INIT);
      cpu_ce_r    <= 1'b0;
      auto_mode_r <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      rate_r      <= rate_s;
      cpu_ce_r    <= cpu_ce_s;
      auto_mode_r <= auto_nxt_s;
      halted_r    <= halt_nxt_s;
    end
  end

  // Next-state, rate, counter and enable decode.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    rate_s       = rate_r;
    cpu_ce_s     = 1'b0;
    auto_cur_s   = (state_r == AUTO) || (state_r == HALT_AUTO);
    halt_cur_s   = (state_r == HALT_MANUAL) || (state_r == HALT_AUTO);
    auto_nxt_s   = auto_cur_s ^ bus.mode_pb;
    halt_nxt_s   = halt_cur_s | bus.hlt;
    period_max_s = (WIDTH'(1) << rate_r) - WIDTH'(1);
    wrap_s       = (cnt_r == period_max_s);

    // Opposing requests in the same cycle cancel out.
    if (bus.faster_pb && !bus.slower_pb) begin
      if (rate_r != RW'(0)) begin
        rate_s = rate_r - RW'(1);
      end else begin
        rate_s = rate_r;
      end
    end else if (bus.slower_pb && !bus.faster_pb) begin
      if (rate_r != RW'(WIDTH - 1)) begin
        rate_s = rate_r + RW'(1);
      end else begin
        rate_s = rate_r;
      end
    end else begin
      rate_s = rate_r;
    end
    rate_chg_s = (rate_s != rate_r);

    case ({halt_nxt_s, auto_nxt_s})
      2'b00:   state_s = MANUAL;
      2'b01:   state_s = AUTO;
      2'b10:   state_s = HALT_MANUAL;
      2'b11:   state_s = HALT_AUTO;
      default: state_s = MANUAL;
    endcase

    // Clears still apply while halted; only counting is frozen.
    if (bus.mode_pb || rate_chg_s) begin
      cnt_s = '0;
    end else if (halt_nxt_s) begin
      cnt_s = cnt_r;
    end else if (!auto_cur_s) begin
      cnt_s = '0;
    end else if (wrap_s) begin
      cnt_s = '0;
    end else begin
      cnt_s = cnt_r + WIDTH'(1);
    end

    if (halt_nxt_s || bus.mode_pb) begin
      cpu_ce_s = 1'b0;
    end else if (!auto_cur_s) begin
      cpu_ce_s = bus.step_pb;
    end else if (rate_chg_s) begin
      cpu_ce_s = 1'b0;
    end else begin
      cpu_ce_s = wrap_s;
    end
  end

  assign bus.cpu_ce    = cpu_ce_r;
  assign bus.auto_mode = auto_mode_r;
  assign bus.halted    = halted_r;
  assign bus.rate      = rate_r;
endmodule
